// File: rtl/exe_sequencer_pkg.sv
// exe_sequencer_pkg: shared unit codes, data-move opcodes and sequencer states
package exe_sequencer_pkg;
  typedef enum logic [1:0] {
    UNIT_ALU = 2'b00,
    UNIT_BR  = 2'b01,
    UNIT_MOV = 2'b10,
    UNIT_ILL = 2'b11
  } unit_t;
  localparam logic [2:0] OP_SDW = 3'b000;
  localparam logic [2:0] OP_LDW = 3'b011;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXEC     = 2'b01,
    MEM_WAIT = 2'b10,
    WB       = 2'b11
  } state_t;
endpackage

// File: rtl/exe_wait_timer.sv
// exe_wait_timer: 8-bit wait-state counter with clear, enable and expired at MAX_WAIT
module exe_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= cnt + 8'd1;
  end
  assign expired = cnt == 8'(MAX_WAIT);
endmodule

// File: rtl/exe_sequencer.sv
// exe_sequencer: execute-stage controller; EXE_PERF_CNT_EN adds retire/mem-stall counters
module exe_sequencer
  import exe_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int RD_W     = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [1:0]      issue_unit,
  input  logic [2:0]      issue_opcode,
  input  logic [RD_W-1:0] issue_rd,
  output logic [2:0]      unit_opcode,
  output logic            alu_en,
  output logic            br_en,
  output logic            mov_en,
  input  logic [31:0]     alu_y,
  input  logic            br_taken,
  input  logic [31:0]     br_offset,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  input  logic [31:0]     mem_rdata,
  output logic            wb_en,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  input  logic            flush,
`ifdef EXE_PERF_CNT_EN
  output logic [31:0]     perf_retired,
  output logic [31:0]     perf_mem_stall,
`endif
  output logic            err
);
  state_t state, next;
  unit_t unit_q;
  logic kill_q, accept, expired, mov_ok, is_ldw, tmo, wb_en_n, redir_n, err_n;
  exe_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(!(state == EXEC || state == MEM_WAIT)),
    .en(state == EXEC || state == MEM_WAIT),
    .expired(expired)
  );
  assign issue_ready = state == IDLE;
  assign accept = issue_valid && issue_ready;
  assign is_ldw = unit_opcode == OP_LDW;
  assign mov_ok = unit_opcode == OP_SDW || is_ldw;
  assign tmo = state == MEM_WAIT && expired && !mem_ack;
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = accept && issue_unit != UNIT_ILL ? EXEC : IDLE;
      EXEC:     next = flush ? IDLE : unit_q != UNIT_MOV ? WB : mov_ok ? MEM_WAIT : IDLE;
      MEM_WAIT: next = mem_ack ? (kill_q || flush ? IDLE : WB) : expired ? IDLE : MEM_WAIT;
      default:  next = IDLE;
    endcase
    wb_en_n = next == WB && wb_rd != '0 && (unit_q == UNIT_ALU || (unit_q == UNIT_MOV && is_ldw));
    redir_n = next == WB && unit_q == UNIT_BR && br_taken;
    err_n = (accept && issue_unit == UNIT_ILL) || tmo ||
            (state == EXEC && !flush && unit_q == UNIT_MOV && !mov_ok);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      unit_q         <= UNIT_ALU;
      kill_q         <= 1'b0;
      unit_opcode    <= '0;
      wb_rd          <= '0;
      alu_en         <= 1'b0;
      br_en          <= 1'b0;
      mov_en         <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      wb_en          <= 1'b0;
      wb_data        <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      err            <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        unit_q      <= unit_t'(issue_unit);
        unit_opcode <= issue_opcode;
        wb_rd       <= issue_rd;
      end
      kill_q         <= state == MEM_WAIT && next == MEM_WAIT && (kill_q || flush);
      alu_en         <= next == EXEC && issue_unit == UNIT_ALU;
      br_en          <= next == EXEC && issue_unit == UNIT_BR;
      mov_en         <= (next == EXEC && issue_unit == UNIT_MOV) || next == MEM_WAIT;
      mem_req        <= next == MEM_WAIT;
      mem_we         <= next == MEM_WAIT && unit_opcode == OP_SDW;
      wb_en          <= wb_en_n;
      redirect_valid <= redir_n;
      err            <= err_n;
      if (wb_en_n) wb_data <= state == EXEC ? alu_y : mem_rdata;
      if (redir_n) redirect_pc <= br_offset;
    end
  end
`ifdef EXE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired   <= '0;
      perf_mem_stall <= '0;
    end else begin
      if (state == WB && !flush) perf_retired <= perf_retired + 32'd1;
      if (state == MEM_WAIT) perf_mem_stall <= perf_mem_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_exe_sequencer.sv
// tb_exe_sequencer: directed self-checking bench for exe_sequencer with MAX_WAIT=4
module tb_exe_sequencer;
  logic clk = 1'b0;
  logic rst, issue_valid, issue_ready, alu_en, br_en, mov_en, br_taken;
  logic mem_req, mem_we, mem_ack, wb_en, redirect_valid, flush, err;
  logic [1:0] issue_unit;
  logic [2:0] issue_opcode, unit_opcode;
  logic [4:0] issue_rd, wb_rd;
  logic [31:0] alu_y, br_offset, mem_rdata, wb_data, redirect_pc;
`ifdef EXE_PERF_CNT_EN
  logic [31:0] perf_retired, perf_mem_stall;
`endif
  int n_tests = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  exe_sequencer #(.MAX_WAIT(4), .RD_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_unit(issue_unit),
    .issue_opcode(issue_opcode),
    .issue_rd(issue_rd),
    .unit_opcode(unit_opcode),
    .alu_en(alu_en),
    .br_en(br_en),
    .mov_en(mov_en),
    .alu_y(alu_y),
    .br_taken(br_taken),
    .br_offset(br_offset),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .wb_en(wb_en),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush(flush),
`ifdef EXE_PERF_CNT_EN
    .perf_retired(perf_retired),
    .perf_mem_stall(perf_mem_stall),
`endif
    .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [1:0] u, input logic [2:0] op, input logic [4:0] rd);
    issue_valid  = 1'b1;
    issue_unit   = u;
    issue_opcode = op;
    issue_rd     = rd;
    tick();
    issue_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_unit = 2'b00;
    issue_opcode = 3'b000;
    issue_rd = 5'd0;
    alu_y = '0;
    br_taken = 1'b0;
    br_offset = '0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    flush = 1'b0;
    tick();
    tick();
    chk("rst_ready", issue_ready, 1);
    chk("rst_req", mem_req, 0);
    chk("rst_wb", wb_en, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    alu_y = 32'h0000_00AA;
    issue(2'b00, 3'b010, 5'd5);
    chk("alu_en", alu_en, 1);
    chk("alu_br_en", br_en, 0);
    chk("alu_mov_en", mov_en, 0);
    chk("alu_op", unit_opcode, 3'b010);
    chk("alu_busy", issue_ready, 0);
    chk("alu_wb_early", wb_en, 0);
    tick();
    chk("alu_wb", wb_en, 1);
    chk("alu_rd", wb_rd, 5);
    chk("alu_data", wb_data, 32'hAA);
    chk("alu_en_off", alu_en, 0);
    tick();
    chk("alu_wb_off", wb_en, 0);
    chk("alu_ready", issue_ready, 1);
    br_taken = 1'b1;
    br_offset = 32'h100;
    issue(2'b01, 3'b001, 5'd3);
    chk("br_en", br_en, 1);
    tick();
    chk("br_redir", redirect_valid, 1);
    chk("br_pc", redirect_pc, 32'h100);
    chk("br_wb", wb_en, 0);
    tick();
    chk("br_redir_off", redirect_valid, 0);
    br_taken = 1'b0;
    issue(2'b01, 3'b001, 5'd3);
    tick();
    chk("brnt_redir", redirect_valid, 0);
    tick();
    issue(2'b10, 3'b011, 5'd7);
    chk("ld_mov_en", mov_en, 1);
    chk("ld_req_exec", mem_req, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("ld_req", mem_req, 1);
      chk("ld_we", mem_we, 0);
      chk("ld_mov_hold", mov_en, 1);
      tick();
    end
    chk("ld_req_ack", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("ld_req_drop", mem_req, 0);
    chk("ld_wb", wb_en, 1);
    chk("ld_rd", wb_rd, 7);
    chk("ld_data", wb_data, 32'hDEAD_BEEF);
    chk("ld_err", err, 0);
    tick();
    chk("ld_ready", issue_ready, 1);
    issue(2'b10, 3'b000, 5'd3);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("st_req", mem_req, 1);
      chk("st_we", mem_we, 1);
      chk("st_err_early", err, 0);
      tick();
    end
    chk("st_req_drop", mem_req, 0);
    chk("st_err", err, 1);
    chk("st_wb", wb_en, 0);
    chk("st_ready", issue_ready, 1);
    tick();
    chk("st_err_once", err, 0);
    issue(2'b10, 3'b011, 5'd9);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_req1", mem_req, 1);
    tick();
    chk("fl_req2", mem_req, 1);
    mem_ack = 1'b1;
    mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    chk("fl_req_drop", mem_req, 0);
    chk("fl_wb", wb_en, 0);
    chk("fl_ready", issue_ready, 1);
    tick();
    chk("fl_wb_late", wb_en, 0);
    alu_y = 32'h55;
    issue(2'b00, 3'b000, 5'd0);
    tick();
    chk("rd0_wb", wb_en, 0);
    tick();
    flush = 1'b1;
    issue(2'b00, 3'b001, 5'd6);
    chk("fl_idle_acc", alu_en, 1);
    tick();
    flush = 1'b0;
    chk("fl_exec_wb", wb_en, 0);
    chk("fl_exec_ready", issue_ready, 1);
    issue(2'b11, 3'b000, 5'd4);
    chk("ill_err", err, 1);
    chk("ill_en", {alu_en, br_en, mov_en}, 0);
    chk("ill_ready", issue_ready, 1);
    tick();
    chk("ill_err_once", err, 0);
    issue(2'b10, 3'b101, 5'd4);
    tick();
    chk("badop_err", err, 1);
    chk("badop_req", mem_req, 0);
    chk("badop_ready", issue_ready, 1);
    issue(2'b10, 3'b011, 5'd8);
    tick();
    chk("rstmw_req", mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmw_req_off", mem_req, 0);
    chk("rstmw_ready", issue_ready, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
